// File: rtl/uart_rx_uint32_bcd.sv
// 8N1 UART receiver (4x oversampled) feeding a decimal line parser that
// packs up to eight ASCII digits into BCD and reports it on CR/LF.
module uart_rx_uint32_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        baud_x4,
  input  logic        serial_rx,
  output logic [31:0] data,
  output logic        data_strobe,
  output logic        overflow,
  output logic        err_strobe
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  logic        sync1_reg;
  logic        sync2_reg;
  logic [2:0]  state_reg;
  logic [1:0]  tick_cnt_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  byte_reg;
  logic        byte_strobe_reg;
  logic        frame_err_reg;

  logic [31:0] acc_reg;
  logic [3:0]  count_reg;
  logic [31:0] data_reg;
  logic        overflow_reg;
  logic        data_strobe_reg;
  logic        err_strobe_reg;

  logic        rx;
  logic        is_digit;
  logic        is_term;

  assign rx = sync2_reg;

  // Synchronizer flops rest high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= serial_rx;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      tick_cnt_reg    <= 2'd0;
      bit_cnt_reg     <= 3'd0;
      shift_reg       <= 8'h00;
      byte_reg        <= 8'h00;
      byte_strobe_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      byte_strobe_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      if (baud_x4) begin
        case (state_reg)
          ST_IDLE: begin
            tick_cnt_reg <= 2'd0;
            if (!rx) state_reg <= ST_START;
          end
          ST_START: begin
            // Second tick after entry lands in the middle of the start bit.
            if (tick_cnt_reg == 2'd1) begin
              tick_cnt_reg <= 2'd0;
              bit_cnt_reg  <= 3'd0;
              state_reg    <= rx ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 2'd1;
            end
          end
          ST_DATA: begin
            tick_cnt_reg <= tick_cnt_reg + 2'd1;
            if (tick_cnt_reg == 2'd3) begin
              shift_reg   <= {rx, shift_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) state_reg <= ST_STOP;
            end
          end
          ST_STOP: begin
            tick_cnt_reg <= tick_cnt_reg + 2'd1;
            if (tick_cnt_reg == 2'd3) begin
              if (rx) begin
                byte_reg        <= shift_reg;
                byte_strobe_reg <= 1'b1;
                state_reg       <= ST_IDLE;
              end else begin
                frame_err_reg <= 1'b1;
                state_reg     <= ST_WAIT_IDLE;
              end
            end
          end
          ST_WAIT_IDLE: begin
            if (rx) state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign is_digit = (byte_reg >= 8'h30) && (byte_reg <= 8'h39);
  assign is_term  = (byte_reg == 8'h0D) || (byte_reg == 8'h0A);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg         <= 32'h0;
      count_reg       <= 4'd0;
      data_reg        <= 32'h0;
      overflow_reg    <= 1'b0;
      data_strobe_reg <= 1'b0;
      err_strobe_reg  <= 1'b0;
    end else begin
      data_strobe_reg <= 1'b0;
      err_strobe_reg  <= 1'b0;
      if (frame_err_reg) begin
        acc_reg        <= 32'h0;
        count_reg      <= 4'd0;
        err_strobe_reg <= 1'b1;
      end else if (byte_strobe_reg) begin
        if (is_digit) begin
          acc_reg <= {acc_reg[27:0], byte_reg[3:0]};
          if (count_reg != 4'd9) count_reg <= count_reg + 4'd1;
        end else if (is_term) begin
          // Empty lines (e.g. the LF of a CRLF pair) are silently dropped.
          if (count_reg != 4'd0) begin
            data_reg        <= acc_reg;
            overflow_reg    <= (count_reg > 4'd8);
            data_strobe_reg <= 1'b1;
            acc_reg         <= 32'h0;
            count_reg       <= 4'd0;
          end
        end else begin
          acc_reg        <= 32'h0;
          count_reg      <= 4'd0;
          err_strobe_reg <= 1'b1;
        end
      end
    end
  end

  assign data        = data_reg;
  assign overflow    = overflow_reg;
  assign data_strobe = data_strobe_reg;
  assign err_strobe  = err_strobe_reg;

endmodule

// File: tb/tb_uart_rx_uint32_bcd.sv
// Directed bench: drives UART frames, predicts events from a line-level
// model and checks DUT outputs every cycle, plus literal scenario checks.
module tb_uart_rx_uint32_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        baud_x4 = 1'b0;
  logic        serial_rx = 1'b1;
  logic [31:0] data;
  logic        data_strobe;
  logic        overflow;
  logic        err_strobe;

  uart_rx_uint32_bcd dut (
    .clk        (clk),
    .reset      (reset),
    .baud_x4    (baud_x4),
    .serial_rx  (serial_rx),
    .data       (data),
    .data_strobe(data_strobe),
    .overflow   (overflow),
    .err_strobe (err_strobe)
  );

  always #5 clk = ~clk;

  localparam int BIT_CLKS = 16;

  typedef struct {
    bit          is_err;
    logic [31:0] d;
    bit          ovf;
  } event_t;

  event_t      exp_q[$];
  int          digits[$];
  logic [31:0] cur_data = 32'h0;
  bit          cur_ovf = 1'b0;
  int          checks = 0;
  int          passes = 0;
  int          ds_count = 0;
  int          es_count = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Free-running 4x baud strobe: one clk high out of every four.
  initial begin
    int tcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      baud_x4 = (tcnt % 4 == 0);
      tcnt++;
    end
  end

  // Line-level model: decimal digits accumulate, terminator reports the
  // last eight as a BCD number, anything else discards the line.
  task automatic model_byte(input logic [7:0] b);
    event_t e;
    if (b >= 8'd48 && b <= 8'd57) begin
      digits.push_back(int'(b) - 48);
    end else if (b == 8'd13 || b == 8'd10) begin
      if (digits.size() > 0) begin
        int first;
        e.is_err = 1'b0;
        e.d = 32'h0;
        first = (digits.size() > 8) ? digits.size() - 8 : 0;
        for (int i = first; i < digits.size(); i++) e.d = e.d * 16 + digits[i];
        e.ovf = (digits.size() > 8);
        exp_q.push_back(e);
        digits.delete();
      end
    end else begin
      e.is_err = 1'b1; e.d = 32'h0; e.ovf = 1'b0;
      exp_q.push_back(e);
      digits.delete();
    end
  endtask

  task automatic model_frame_err();
    event_t e;
    e.is_err = 1'b1; e.d = 32'h0; e.ovf = 1'b0;
    exp_q.push_back(e);
    digits.delete();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    if (stop_bit) model_byte(b);
    else model_frame_err();
    serial_rx = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      wait_clk(BIT_CLKS);
    end
    serial_rx = stop_bit;
    wait_clk(BIT_CLKS);
    serial_rx = 1'b1;
    wait_clk(3);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
    wait_clk(40);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    serial_rx = 1'b1;
    exp_q.delete();
    digits.delete();
    cur_data = 32'h0;
    cur_ovf = 1'b0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(1);
  endtask

  // Compare process: every strobe must match the next predicted event and
  // data/overflow must equal the last delivered value on every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_strobe && err_strobe)
        check(1'b0, "both_strobes", {30'h0, data_strobe, err_strobe}, 32'h0);
      if (data_strobe || err_strobe) begin
        if (data_strobe) ds_count++;
        if (err_strobe) es_count++;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_strobe", {30'h0, data_strobe, err_strobe}, 32'h0);
        end else begin
          event_t e;
          e = exp_q.pop_front();
          check(err_strobe == e.is_err, "strobe_kind", {31'h0, err_strobe}, {31'h0, e.is_err});
          if (!e.is_err) begin
            cur_data = e.d;
            cur_ovf = e.ovf;
          end
        end
      end
      check(data == cur_data && overflow == cur_ovf, "hold_value", data, cur_data);
    end
  end

  initial begin
    int ds0;
    int es0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(1);
    check(data == 32'h0, "reset_data", data, 32'h0);
    check({overflow, data_strobe, err_strobe} == 3'b000, "reset_flags",
          {29'h0, overflow, data_strobe, err_strobe}, 32'h0);
    wait_clk(20);

    ds0 = ds_count; es0 = es_count;
    send_str("12345678\r");
    check(data == 32'h12345678, "s1_data", data, 32'h12345678);
    check(overflow == 1'b0, "s1_ovf", {31'h0, overflow}, 32'h0);
    check(ds_count == ds0 + 1, "s1_nstrobe", ds_count, ds0 + 1);
    check(es_count == es0, "s1_nerr", es_count, es0);

    ds0 = ds_count;
    send_str("42\r\n");
    check(data == 32'h00000042, "s2_data", data, 32'h42);
    check(ds_count == ds0 + 1, "s2_nstrobe", ds_count, ds0 + 1);

    send_str("1234567890\n");
    check(data == 32'h34567890, "s3_data", data, 32'h34567890);
    check(overflow == 1'b1, "s3_ovf", {31'h0, overflow}, 32'h1);
    send_str("7\n");
    check(data == 32'h00000007, "s3b_data", data, 32'h7);
    check(overflow == 1'b0, "s3b_ovf", {31'h0, overflow}, 32'h0);

    ds0 = ds_count; es0 = es_count;
    send_str("12a5\r");
    check(es_count == es0 + 1, "s4_nerr", es_count, es0 + 1);
    check(data == 32'h00000005, "s4_data", data, 32'h5);
    check(ds_count == ds0 + 1, "s4_nstrobe", ds_count, ds0 + 1);

    // Stop bit low, line then held low three more bit times.
    es0 = es_count;
    model_frame_err();
    serial_rx = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      serial_rx = (8'h31 >> i) & 8'h01;
      wait_clk(BIT_CLKS);
    end
    serial_rx = 1'b0;
    wait_clk(BIT_CLKS * 4);
    serial_rx = 1'b1;
    wait_clk(BIT_CLKS * 2);
    check(es_count == es0 + 1, "s5_nerr", es_count, es0 + 1);
    send_str("9\r");
    check(data == 32'h00000009, "s5_data", data, 32'h9);
    check(es_count == es0 + 1, "s5_nerr_after", es_count, es0 + 1);

    // One baud_x4 period low glitch must not produce any event.
    ds0 = ds_count; es0 = es_count;
    serial_rx = 1'b0;
    wait_clk(4);
    serial_rx = 1'b1;
    wait_clk(BIT_CLKS * 12);
    check(ds_count == ds0 && es_count == es0, "glitch_quiet", ds_count + es_count, ds0 + es0);

    // Reset in the middle of "55", then a fresh line.
    send_frame(8'h35, 1'b1);
    serial_rx = 1'b0;
    wait_clk(BIT_CLKS);
    serial_rx = 1'b1;
    wait_clk(BIT_CLKS * 2);
    do_reset();
    check(data == 32'h0, "rst_mid_data", data, 32'h0);
    wait_clk(BIT_CLKS * 2);
    ds0 = ds_count; es0 = es_count;
    send_str("6\r");
    check(data == 32'h00000006, "s6_data", data, 32'h6);
    check(ds_count == ds0 + 1 && es_count == es0, "s6_counts", ds_count, ds0 + 1);

    wait_clk(20);
    check(exp_q.size() == 0, "events_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
